conv_sequencer: RTL
===================

# conv_sequencer

Controller for the convolution engine's accumulator. It walks a K×K kernel over an IMG_W×IMG_H 8-bit image, using valid-mode convolution with no padding. It fetches pixel/weight pairs from the image and kernel memories and drives the shared `Accumilator` register through its `data_in`/`w_en` port to build each dot product. Each finished sum is written to the output buffer. It sits between the top-level processor control (start/done) and the memory and accumulator datapath.

## Interface
- `IMG_W`, 8: image width in pixels; must be ≥ K.
- `IMG_H`, 8: image height in pixels; must be ≥ K.
- `K`, 3: kernel side; kernel is K×K.
- `ADDR_W`, 16: address width of the image and output memories.
- `DATA_W`, 32: accumulator and output data width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin one full-frame convolution; sampled only in IDLE.
- `busy` out 1: high from the first CLEAR cycle through the last WRITE cycle.
- `done` out 1: one-cycle pulse after the last output write.
- `img_addr` out ADDR_W: image memory read address.
- `img_data` in 8: unsigned pixel, valid one cycle after `img_addr`.
- `ker_addr` out 8: kernel memory read address, range 0..K²−1.
- `ker_data` in 8: signed weight, valid one cycle after `ker_addr`.
- `acc_din` out DATA_W: drives accumulator `data_in`.
- `acc_w_en` out 1: drives accumulator `w_en`. Accumulator `inc` is tied 0 by the top level.
- `acc_q` in DATA_W: accumulator `data_out`.
- `out_addr` out ADDR_W: output buffer write address.
- `out_data` out DATA_W: output value.
- `out_we` out 1: output write strobe.

## Operation
- FSM states and transitions:
  - IDLE → CLEAR on `start`.
  - CLEAR → FETCH.
  - FETCH → MAC.
  - MAC → FETCH while taps remain; MAC → WRITE after tap K²−1.
  - WRITE → CLEAR while output pixels remain; WRITE → DONE after the last pixel.
  - DONE → IDLE.
- Counters:
  - Output position (row, col): row 0..IMG_H−K, col 0..IMG_W−K, raster order, col fastest.
  - Tap (ky, kx): 0..K−1 each, kx fastest.
- CLEAR: `acc_w_en`=1, `acc_din`=0. Tap counters reset to 0.
- FETCH:
  - `img_addr` = (row+ky)·IMG_W + (col+kx).
  - `ker_addr` = ky·K + kx.
  - Addresses are registered outputs, stable through the following MAC cycle.
- MAC:
  - `acc_w_en`=1.
  - `acc_din` = `acc_q` + sext(prod), where prod = {1'b0,img_data} × signed ker_data, a 17-bit signed value.
  - Two's-complement wrap at DATA_W; no saturation.
  - Tap counter advances.
- WRITE:
  - `out_we`=1, `out_data`=`acc_q`.
  - `out_addr` = row·(IMG_W−K+1) + col.
  - Output position advances.
- `start` outside IDLE is ignored, including during the DONE cycle.
- All strobes (`acc_w_en`, `out_we`, `done`) are 0 in every state not listed above.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - `busy`, `done`, `acc_w_en`, `out_we` = 0.
  - `img_addr`, `ker_addr`, `out_addr`, `acc_din`, `out_data` = 0.
- Memory reads are synchronous with 1-cycle latency; the design depends on FETCH/MAC alternation.
- Cycles per output pixel: P = 2 + 2K², which is 20 for K=3.
- Frame latency:
  - N = (IMG_W−K+1)(IMG_H−K+1) output pixels.
  - `busy` rises in the cycle after the accepting `start` edge.
  - `busy` stays high for exactly N·P cycles.
  - `done` is high in the next cycle.
- `out_data` equals the full sum because the final MAC write lands on the edge entering WRITE.
- IMG_W = K or IMG_H = K: a single column or row; wrap logic must not skip or repeat positions.
- `rst` asserted mid-frame:
  - Immediate return to IDLE; all outputs take their reset values asynchronously.
  - No partial `out_we` or `done`.
  - The accumulator's contents are don't-care, because the next CLEAR overwrites them.

## Structure
- Package `conv_pkg` holds:
  - State enum (IDLE, CLEAR, FETCH, MAC, WRITE, DONE).
  - PIX_W=8, WGT_W=8, PROD_W=17.
- Sub-module `conv_addr_gen` holds the row/col/ky/kx counters, address arithmetic, and last-tap/last-pixel flags. The FSM and MAC adder stay in `conv_sequencer`.

## Test plan
- 4×4 image, all pixels 1, K=3, all weights 1, then `start` → 4 writes to `out_addr` 0..3, each `out_data`=9; `done` 80 cycles after `busy` rises.
- 4×4 image, pixel p[i]=i, identity kernel (center weight 1, others 0) → `out_data` = 5, 6, 9, 10 at addresses 0..3.
- All pixels 255, all weights −128 → each `out_data`=0xFFFB8480 (−293760).
- Reset pulse during the second pixel's MAC phase → all outputs 0 immediately. A new `start` then yields full correct results with no stale sum.
- `start` held high through the whole frame and the DONE cycle → exactly one frame runs, and a new frame begins only after IDLE is re-entered.
- Parameters IMG_W=3, IMG_H=5, K=3 → 3 writes at `out_addr` 0..2 with correct image addresses per tap.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and datapath widths for the convolution sequencer
package conv_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, MAC, WRITE, DONE} state_t;
    localparam int PIX_W  = 8;
    localparam int WGT_W  = 8;
    localparam int PROD_W = 17;
endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: output-position and kernel-tap counters with registered memory addresses
module conv_addr_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tap_clr,
    input  logic              tap_adv,
    input  logic              pix_adv,
    output logic [ADDR_W-1:0] img_addr,
    output logic [7:0]        ker_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              last_tap,
    output logic              last_pix
);
    localparam logic [7:0]        KM = 8'(K - 1);
    localparam logic [ADDR_W-1:0] RM = ADDR_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0] CM = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] W  = ADDR_W'(IMG_W);
    logic [ADDR_W-1:0] row, col;
    logic [7:0]        ky, kx, nky, nkx;
    // Addresses are loaded from the post-update tap so the next FETCH sees the advanced tap
    always_comb begin
        nkx = tap_clr ? '0 : tap_adv ? (kx == KM ? '0 : kx + 8'd1) : kx;
        nky = tap_clr ? '0 : (tap_adv && kx == KM) ? (ky == KM ? '0 : ky + 8'd1) : ky;
    end
    assign last_tap = ky == KM && kx == KM;
    assign last_pix = row == RM && col == CM;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            ky       <= '0;
            kx       <= '0;
            img_addr <= '0;
            ker_addr <= '0;
            out_addr <= '0;
        end else begin
            ky <= nky;
            kx <= nkx;
            if (tap_clr || tap_adv) begin
                img_addr <= (row + ADDR_W'(nky)) * W + col + ADDR_W'(nkx);
                ker_addr <= nky * 8'(K) + nkx;
            end
            if (pix_adv) begin
                col      <= col == CM ? '0 : col + 1'b1;
                if (col == CM) row <= row == RM ? '0 : row + 1'b1;
                out_addr <= last_pix ? '0 : out_addr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: FSM and MAC adder walking a KxK kernel over the image into the accumulator
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [PIX_W-1:0]  img_data,
    output logic [7:0]        ker_addr,
    input  logic [WGT_W-1:0]  ker_data,
    output logic [DATA_W-1:0] acc_din,
    output logic              acc_w_en,
    input  logic [DATA_W-1:0] acc_q,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we
);
    state_t state;
    logic   last_tap, last_pix;
    logic signed [PROD_W-1:0] prod;
    conv_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .tap_clr  (state == CLEAR),
        .tap_adv  (state == MAC),
        .pix_adv  (state == WRITE),
        .img_addr (img_addr),
        .ker_addr (ker_addr),
        .out_addr (out_addr),
        .last_tap (last_tap),
        .last_pix (last_pix)
    );
    // Pixel is unsigned, so a zero MSB keeps it positive in the signed multiply
    assign prod     = $signed({1'b0, img_data}) * $signed(ker_data);
    assign acc_din  = state == MAC ? acc_q + {{(DATA_W - PROD_W){prod[PROD_W-1]}}, prod} : '0;
    assign out_data = out_we ? acc_q : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_w_en <= 1'b0;
            out_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= CLEAR;
                    busy     <= 1'b1;
                    acc_w_en <= 1'b1;
                end
                CLEAR: begin
                    state    <= FETCH;
                    acc_w_en <= 1'b0;
                end
                FETCH: begin
                    state    <= MAC;
                    acc_w_en <= 1'b1;
                end
                MAC: begin
                    state    <= last_tap ? WRITE : FETCH;
                    acc_w_en <= 1'b0;
                    out_we   <= last_tap;
                end
                WRITE: begin
                    state    <= last_pix ? DONE : CLEAR;
                    out_we   <= 1'b0;
                    busy     <= !last_pix;
                    done     <= last_pix;
                    acc_w_en <= !last_pix;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
